// File: rtl/dram_cmd_sequencer.sv
// Per-bank open-row tracking and PRE/ACT/RD/WR expansion over a 4-phase cmd_req/cmd_ack handshake.
// Optional close-page policy: define DRAM_SEQ_CLOSE_PAGE_EN.
module dram_cmd_sequencer #(
    parameter int NUM_OF_BANKS = 8,
    parameter int NUM_OF_ROWS  = 128,
    parameter int NUM_OF_COLS  = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int T_RCD        = 2,
    parameter int T_RP         = 2,
    localparam int BANK_W = $clog2(NUM_OF_BANKS),
    localparam int ROW_W  = $clog2(NUM_OF_ROWS),
    localparam int COL_W  = $clog2(NUM_OF_COLS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_rw,
    input  logic [BANK_W-1:0]     req_bank,
    input  logic [ROW_W-1:0]      req_row,
    input  logic [COL_W-1:0]      req_col,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  cmd_req,
    input  logic                  cmd_ack,
    output logic [1:0]            cmd,
    output logic [BANK_W-1:0]     cmd_bank,
    output logic [ROW_W-1:0]      cmd_row,
    output logic [COL_W-1:0]      cmd_col,
    output logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [DATA_WIDTH-1:0] dram_rdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data
);

`ifdef DRAM_SEQ_CLOSE_PAGE_EN
    localparam bit CLOSE_PAGE = 1'b1;
`else
    localparam bit CLOSE_PAGE = 1'b0;
`endif

    localparam int T_MAX = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int CNT_W = $clog2(T_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RELEASE, S_WAIT} state_t;
    typedef enum logic [1:0] {C_PRE = 2'b00, C_ACT = 2'b01, C_RD = 2'b10, C_WR = 2'b11} cmd_t;

    state_t                r_state;
    state_t                w_state_nxt;
    cmd_t                  r_cmd;
    logic                  r_rw;
    logic [BANK_W-1:0]     r_bank;
    logic [ROW_W-1:0]      r_row;
    logic [COL_W-1:0]      r_col;
    logic [DATA_WIDTH-1:0] r_data;
    logic [ROW_W-1:0]      r_cmd_row;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_final;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_open_vld [NUM_OF_BANKS];
    logic [ROW_W-1:0]      r_open_row [NUM_OF_BANKS];

    logic                  w_hit;
    logic                  w_wait_done;
    cmd_t                  w_rw_cmd;

    assign w_hit       = r_open_vld[req_bank] && (r_open_row[req_bank] == req_row);
    assign w_wait_done = (r_cnt <= CNT_W'(1));
    assign w_rw_cmd    = r_rw ? C_WR : C_RD;

    assign req_ready = (r_state == S_IDLE);
    assign cmd_req   = (r_state == S_ISSUE);
    assign cmd       = r_cmd;
    assign cmd_bank  = r_bank;
    assign cmd_row   = r_cmd_row;
    assign cmd_col   = r_col;
    assign cmd_wdata = (r_cmd == C_WR) ? r_data : '0;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (req_valid) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (cmd_ack) w_state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                if (!cmd_ack) begin
                    case (r_cmd)
                        C_PRE, C_ACT: w_state_nxt = S_WAIT;
                        default:      w_state_nxt = CLOSE_PAGE ? S_ISSUE : S_IDLE;
                    endcase
                end
            end
            S_WAIT: begin
                if (w_wait_done) begin
                    w_state_nxt = (r_cmd == C_PRE && r_final) ? S_IDLE : S_ISSUE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd       <= C_PRE;
            r_rw        <= 1'b0;
            r_bank      <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_data      <= '0;
            r_cmd_row   <= '0;
            r_cnt       <= '0;
            r_final     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            for (int unsigned i = 0; i < NUM_OF_BANKS; i++) begin
                r_open_vld[i] <= 1'b0;
                r_open_row[i] <= '0;
            end
        end else begin
            r_rsp_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_rw    <= req_rw;
                        r_bank  <= req_bank;
                        r_row   <= req_row;
                        r_col   <= req_col;
                        r_data  <= req_data;
                        r_final <= 1'b0;
                        if (w_hit) begin
                            r_cmd     <= req_rw ? C_WR : C_RD;
                            r_cmd_row <= req_row;
                        end else if (!r_open_vld[req_bank]) begin
                            r_cmd     <= C_ACT;
                            r_cmd_row <= req_row;
                        end else begin
                            r_cmd     <= C_PRE;
                            r_cmd_row <= r_open_row[req_bank];
                        end
                    end
                end
                S_ISSUE: begin
                    if (cmd_ack) begin
                        case (r_cmd)
                            C_PRE: r_open_vld[r_bank] <= 1'b0;
                            C_ACT: begin
                                r_open_vld[r_bank] <= 1'b1;
                                r_open_row[r_bank] <= r_row;
                            end
                            C_RD:    r_rsp_data <= dram_rdata;
                            default: ;
                        endcase
                    end
                end
                S_RELEASE: begin
                    if (!cmd_ack) begin
                        case (r_cmd)
                            C_PRE: r_cnt <= CNT_W'(T_RP);
                            C_ACT: r_cnt <= CNT_W'(T_RCD);
                            default: begin
                                r_rsp_valid <= (r_cmd == C_RD);
                                // Close-page: chain a final PRE of the row just accessed.
                                if (CLOSE_PAGE) begin
                                    r_cmd     <= C_PRE;
                                    r_cmd_row <= r_row;
                                    r_final   <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                S_WAIT: begin
                    if (w_wait_done) begin
                        r_cnt <= '0;
                        if (r_cmd == C_PRE) begin
                            if (!r_final) begin
                                r_cmd     <= C_ACT;
                                r_cmd_row <= r_row;
                            end
                        end else begin
                            r_cmd <= w_rw_cmd;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_cmd_sequencer.sv
// Directed bench for dram_cmd_sequencer: command and read-response scoreboards fed by a handshaking DRAM responder.
`timescale 1ns/1ps
module tb_dram_cmd_sequencer;
    localparam int TRCD = 2;
    localparam int TRP  = 2;
    localparam int BW = 3, RW = 7, CW = 3, DW = 8;
    localparam logic [1:0] PRE = 2'b00, ACT = 2'b01, RD = 2'b10, WR = 2'b11;
    localparam int HIT = 0, CLOSED = 1, CONFLICT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_rw;
    logic [BW-1:0] req_bank;
    logic [RW-1:0] req_row;
    logic [CW-1:0] req_col;
    logic [DW-1:0] req_data;
    logic          cmd_req, cmd_ack;
    logic [1:0]    cmd;
    logic [BW-1:0] cmd_bank;
    logic [RW-1:0] cmd_row;
    logic [CW-1:0] cmd_col;
    logic [DW-1:0] cmd_wdata, dram_rdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;

    always #5 clk = ~clk;

    dram_cmd_sequencer #(
        .NUM_OF_BANKS(8), .NUM_OF_ROWS(128), .NUM_OF_COLS(8),
        .DATA_WIDTH(DW), .T_RCD(TRCD), .T_RP(TRP)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_bank(req_bank), .req_row(req_row), .req_col(req_col), .req_data(req_data),
        .cmd_req(cmd_req), .cmd_ack(cmd_ack), .cmd(cmd), .cmd_bank(cmd_bank),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_wdata(cmd_wdata),
        .dram_rdata(dram_rdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data)
    );

    typedef struct {
        logic [1:0]    c;
        logic [BW-1:0] b;
        logic [RW-1:0] r;
        logic [CW-1:0] col;
        logic [DW-1:0] d;    // wdata for WR, DRAM return data for RD
        int            gap;  // required idle cycles before this command, -1 = unchecked
    } exp_t;

    exp_t          cmd_q[$];
    logic [DW-1:0] rsp_q[$];
    int checks = 0;
    int failures = 0;
    int ack_delay = 1;
    int ack_hold = 1;
    int phase = 0;
    int dly = 0;
    int hold = 0;
    int gap = 0;
    exp_t cur;
    logic [31:0] snap;
    logic prev_rsp = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fields();
        return {9'b0, cmd, cmd_bank, cmd_row, cmd_col, cmd_wdata};
    endfunction

    // DRAM responder: pops and checks each command, then runs the 4-phase handshake.
    initial begin
        cmd_ack = 1'b0;
        dram_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cmd_ack = 1'b0;
                phase = 0;
                gap = 0;
                dly = 0;
            end else begin
                case (phase)
                    0: begin
                        if (cmd_req) begin
                            check("cmd_expected", 32'(cmd_q.size() != 0), 1);
                            if (cmd_q.size() != 0) begin
                                cur = cmd_q.pop_front();
                                check("cmd_code", 32'(cmd), 32'(cur.c));
                                check("cmd_bank", 32'(cmd_bank), 32'(cur.b));
                                if (cur.c == PRE || cur.c == ACT) check("cmd_row", 32'(cmd_row), 32'(cur.r));
                                if (cur.c == RD || cur.c == WR) check("cmd_col", 32'(cmd_col), 32'(cur.col));
                                if (cur.c == WR) check("cmd_wdata", 32'(cmd_wdata), 32'(cur.d));
                                if (cur.gap >= 0) check("idle_gap", 32'(gap), 32'(cur.gap));
                                snap = fields();
                                dly = ack_delay;
                                phase = 1;
                                if (dly == 0) begin
                                    cmd_ack = 1'b1;
                                    dram_rdata = cur.d;
                                    hold = ack_hold;
                                    phase = 2;
                                end
                            end
                        end else begin
                            gap++;
                        end
                    end
                    1: begin
                        check("cmd_req_held", 32'(cmd_req), 1);
                        check("cmd_fields_stable", fields(), snap);
                        dly--;
                        if (dly == 0) begin
                            cmd_ack = 1'b1;
                            dram_rdata = cur.d;
                            hold = ack_hold;
                            phase = 2;
                        end
                    end
                    default: begin
                        check("cmd_req_low_while_ack", 32'(cmd_req), 0);
                        hold--;
                        if (hold <= 0) begin
                            cmd_ack = 1'b0;
                            phase = 0;
                            gap = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Read-response monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (prev_rsp) check("rsp_pulse_width", 32'(rsp_valid), 0);
                if (rsp_valid) begin
                    check("rsp_expected", 32'(rsp_q.size() != 0), 1);
                    if (rsp_q.size() != 0) check("rsp_data", 32'(rsp_data), 32'(rsp_q.pop_front()));
                end
                prev_rsp = rsp_valid;
            end else begin
                prev_rsp = 1'b0;
            end
        end
    end

    task automatic push_cmd(input logic [1:0] c, input int b, input int r, input int col, input int d, input int g);
        exp_t e;
        e.c = c;
        e.b = b[BW-1:0];
        e.r = r[RW-1:0];
        e.col = col[CW-1:0];
        e.d = d[DW-1:0];
        e.gap = g;
        cmd_q.push_back(e);
    endtask

    task automatic send(input logic rw, input int b, input int r, input int col, input int d);
        int n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_before_req", 32'(req_ready), 1);
        req_valid = 1'b1;
        req_rw = rw;
        req_bank = b[BW-1:0];
        req_row = r[RW-1:0];
        req_col = col[CW-1:0];
        req_data = d[DW-1:0];
        @(negedge clk);
        req_valid = 1'b0;
        check("req_ready_drops", 32'(req_ready), 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(req_ready && phase == 0 && !cmd_ack && cmd_q.size() == 0 && rsp_q.size() == 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("txn_complete", 32'(n < 2000), 1);
        @(negedge clk);
    endtask

    task automatic access(input logic rw, input int b, input int r, input int col, input int d,
                          input int kind, input int oldrow);
        logic [1:0] rwc;
        rwc = rw ? WR : RD;
`ifdef DRAM_SEQ_CLOSE_PAGE_EN
        push_cmd(ACT, b, r, 0, 0, -1);
        push_cmd(rwc, b, r, col, d, TRCD);
        push_cmd(PRE, b, r, 0, 0, 0);
`else
        if (kind == CONFLICT) begin
            push_cmd(PRE, b, oldrow, 0, 0, -1);
            push_cmd(ACT, b, r, 0, 0, TRP);
            push_cmd(rwc, b, r, col, d, TRCD);
        end else if (kind == CLOSED) begin
            push_cmd(ACT, b, r, 0, 0, -1);
            push_cmd(rwc, b, r, col, d, TRCD);
        end else begin
            push_cmd(rwc, b, r, col, d, -1);
        end
`endif
        if (!rw) rsp_q.push_back(d[DW-1:0]);
        send(rw, b, r, col, d);
        wait_idle();
    endtask

    initial begin
        int n;
        rst = 1'b1;
        req_valid = 1'b0;
        req_rw = 1'b0;
        req_bank = '0;
        req_row = '0;
        req_col = '0;
        req_data = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 1);
        check("rst_cmd_req", 32'(cmd_req), 0);
        check("rst_cmd", 32'(cmd), 0);
        check("rst_cmd_bank", 32'(cmd_bank), 0);
        check("rst_cmd_row", 32'(cmd_row), 0);
        check("rst_cmd_col", 32'(cmd_col), 0);
        check("rst_cmd_wdata", 32'(cmd_wdata), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        rst = 1'b0;
        @(negedge clk);

        access(1'b1, 3, 5, 2, 8'hA5, CLOSED, 0);
        access(1'b0, 3, 5, 2, 8'h3C, HIT, 0);
        access(1'b0, 3, 9, 1, 8'h5A, CONFLICT, 5);

        ack_delay = 8;
        ack_hold = 3;
        access(1'b1, 3, 9, 7, 8'h11, HIT, 0);
        access(1'b0, 3, 1, 4, 8'hC3, CONFLICT, 9);

        ack_delay = 0;
        ack_hold = 1;
        access(1'b0, 6, 100, 0, 8'h96, CLOSED, 0);
        access(1'b1, 6, 100, 5, 8'hFF, HIT, 0);
        access(1'b0, 3, 1, 6, 8'h0F, HIT, 0);

        // Reset while the ACT handshake is pending.
        ack_delay = 1000;
        push_cmd(ACT, 2, 7, 0, 0, -1);
        send(1'b0, 2, 7, 1, 8'h77);
        n = 0;
        while (!cmd_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("act_raised_before_reset", 32'(cmd_req), 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_req_ready", 32'(req_ready), 1);
        check("midrst_cmd_req", 32'(cmd_req), 0);
        check("midrst_rsp_valid", 32'(rsp_valid), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ack_delay = 1;
        @(negedge clk);
        access(1'b0, 2, 7, 1, 8'h77, CLOSED, 0);
        access(1'b0, 3, 1, 6, 8'h0F, CLOSED, 0);

`ifdef DRAM_SEQ_CLOSE_PAGE_EN
        access(1'b0, 1, 4, 3, 8'h41, CLOSED, 0);
        access(1'b0, 1, 4, 3, 8'h42, CLOSED, 0);
`endif

        check("cmd_q_drained", 32'(cmd_q.size()), 0);
        check("rsp_q_drained", 32'(rsp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
